// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load-data byte/half/word extractor with sign/zero extension and two-beat span merge
// Optional feature macro: LOAD_ALIGN_SPAN_EN (two-beat merge of word-spanning loads).
module load_align_unit #(
    parameter int DATA_W = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_rd,
    output logic              mem_next,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);
    localparam int BYTES  = DATA_W / 8;
    localparam int MAX_SZ = $clog2(BYTES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_LO = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [1:0]        size_c;
    logic              span;

    // Shift the {upper, lower} beat pair down to the field, then extend above bit N-1.
    function automatic logic [DATA_W-1:0] fmt(input logic [2*DATA_W-1:0] pair,
                                              input logic [OFF_W-1:0]    off,
                                              input logic [1:0]          sz,
                                              input logic                sgn);
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   res;
        logic                ext;
        int                  nbits;
        sh    = pair >> {off, 3'b000};
        nbits = 8 << sz;
        ext   = sgn & sh[nbits-1];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nbits) ? sh[i] : ext;
        end
        return res;
    endfunction

    always_comb begin
        size_c = (32'(req_size) > MAX_SZ) ? 2'(MAX_SZ) : req_size;
        span   = (32'(off_q) + (32'd1 << size_q)) > BYTES;
    end

`ifdef LOAD_ALIGN_SPAN_EN
    logic [DATA_W-1:0] beat_q, beat_d;
`endif

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef LOAD_ALIGN_SPAN_EN
        beat_d  = beat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT_LO;
                    off_d   = req_offset;
                    size_d  = size_c;
                    sgn_d   = req_signed;
                end
            end
            S_WAIT_LO: begin
                if (mem_valid) begin
                    if (span) begin
`ifdef LOAD_ALIGN_SPAN_EN
                        beat_d  = mem_data;
                        state_d = S_WAIT_HI;
`else
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
`endif
                    end else begin
                        data_d  = fmt({{DATA_W{1'b0}}, mem_data}, off_q, size_q, sgn_q);
                        err_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_WAIT_HI: begin
`ifdef LOAD_ALIGN_SPAN_EN
                if (mem_valid) begin
                    data_d  = fmt({mem_data, beat_q}, off_q, size_q, sgn_q);
                    err_d   = 1'b0;
                    state_d = S_HOLD;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef LOAD_ALIGN_SPAN_EN
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef LOAD_ALIGN_SPAN_EN
            beat_q  <= beat_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_rd    = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
`ifdef LOAD_ALIGN_SPAN_EN
    assign mem_next  = (state_q == S_WAIT_HI);
`else
    assign mem_next  = 1'b0;
`endif
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_err   = err_q;
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised load-data formatter between the memory read port and the regfile write path. It extracts a byte, halfword or word field at any byte offset within a DATA_W memory word, and zero- or sign-extends it to DATA_W. Accesses that straddle a word boundary are merged across two memory beats. Request, memory and result sides are decoupled by a small FSM with valid/ready handshakes.

Parameters:
DATA_W, 16, memory/regfile word width in bits; power of 2, 16..64.
OFF_W, $clog2(DATA_W/8), byte-offset width; derived, not overridden.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; synchronous, active-low
req_valid  in  1  load request valid
req_ready  out  1  block can accept a request; high only in IDLE
req_offset  in  OFF_W  byte offset of field within first word (byte 0 = bits 7:0, little-endian)
req_size  in  2  log2 of field bytes (0=byte, 1=half, 2=32b, 3=64b); values above log2(DATA_W/8) clamp to full word
req_signed  in  1  1 = sign-extend, 0 = zero-extend
mem_rd  out  1  requesting a memory beat; high in WAIT_LO/WAIT_HI
mem_next  out  1  high in WAIT_HI; address logic supplies word+1
mem_valid  in  1  memory beat valid this cycle
mem_data  in  DATA_W  memory beat data
out_valid  out  1  formatted result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  formatted, extended result
out_err  out  1  misaligned-span error flag, qualified by out_valid

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; out_valid=0, out_data=0, out_err=0, all request fields cleared. mem_rd=0, mem_next=0, req_ready=1 from the first post-reset cycle. Reset mid-transaction abandons it with no out_valid pulse. A mem_valid after reset is ignored.
- States: IDLE, WAIT_LO, WAIT_HI, HOLD. mem_rd, mem_next and req_ready decode from state.
- IDLE: req_valid=1 captures offset, clamped size and signed; goes to WAIT_LO.
- WAIT_LO: on mem_valid, store the beat.
  - If offset + (1<<size) > DATA_W/8 (span) and the feature is on, go to WAIT_HI.
  - Otherwise register the formatted result and go to HOLD.
- WAIT_HI: on mem_valid, merge bytes. The low bytes come from the stored beat bytes [offset..DATA_W/8-1]. The upper bytes come from the new beat starting at byte 0. Register the result and go to HOLD.
- mem_valid in IDLE or HOLD is ignored.
- HOLD: out_valid=1. out_data and out_err stay stable until out_ready=1. On the out_ready cycle go to IDLE; out_valid drops next cycle. No request overlap: req_ready=0 in HOLD.
- Latency: out_valid rises on the cycle after the final mem_valid beat. Best-case throughput is one load per 3 cycles.
- Formatting:
  - Field is N=8<<size bits.
  - Bits [N-1:0] of out_data hold the field.
  - Bits [DATA_W-1:N] hold the field MSB when req_signed=1, else 0.
  - Full-word size at offset 0 is exact passthrough.
- Size clamp: req_size above log2(DATA_W/8) behaves as full word. With DATA_W=16, size 2 and 3 are treated as 1.

Optional Feature:
Macro LOAD_ALIGN_SPAN_EN.
- Defined: spanning accesses take the two-beat WAIT_HI merge; out_err is always 0.
- Undefined: WAIT_HI logic is not built. A spanning access goes WAIT_LO to HOLD after one beat with out_err=1 and out_data=0, and mem_next is tied 0. Non-spanning behaviour is identical in both builds.

Test Plan:
- DATA_W=16, byte, offset 1, signed=1, beat 0x80AB -> out_data 0xFF80, out_err 0, out_valid one cycle after mem_valid.
- Byte, offset 0, signed=0, beat 0x80AB -> 0x00AB. Same with signed=1 -> 0xFFAB.
- Word, offset 0, beat 0x80AB -> 0x80AB passthrough. req_size=3 gives the identical result.
- Word, offset 1, beats 0x3412 then 0x7856:
  - SPAN_EN defined -> mem_next=1 during the second beat, out_data 0x5634, out_err 0.
  - SPAN_EN undefined -> single beat, out_data 0x0000, out_err 1.
- Back-pressure: out_ready held 0 for 5 cycles -> out_valid and out_data stable, req_ready=0, an extra mem_valid is ignored. out_ready=1 -> IDLE next cycle.
- rst_n=0 during WAIT_HI -> next cycle state IDLE, out_valid 0, mem_rd 0, req_ready 1. No result is produced for the abandoned load.
